// File: rtl/sw_target_feeder.sv
// sw_target_feeder: target-side driver for the Smith-Waterman scoring array.
// Loads penalties/query, streams two target sequences into the scorer's
// time-multiplexed channel slots, and returns unbiased scores on a single
// valid/ready result stream.
// Optional build macro: SW_FEEDER_TIMEOUT_EN adds a per-channel DRAIN timeout.
module sw_target_feeder #(
  parameter int SCORE_WIDTH = 12,
  parameter int LENGTH      = 128,
  parameter int ADDR_WIDTH  = $clog2(LENGTH + 1) + 1,
  parameter logic [SCORE_WIDTH-1:0] ZERO = {1'b1, {(SCORE_WIDTH-1){1'b0}}},
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic [ADDR_WIDTH-1:0]  cfg_qlen,
  output logic                   sc_ld_p,
  output logic                   sc_ld_q,
  output logic [ADDR_WIDTH-1:0]  sc_output_select,
  input  logic                   sc_ready,
  input  logic                   tgt0_valid,
  input  logic                   tgt1_valid,
  input  logic [1:0]             tgt0_base,
  input  logic [1:0]             tgt1_base,
  input  logic                   tgt0_last,
  input  logic                   tgt1_last,
  output logic                   tgt0_ready,
  output logic                   tgt1_ready,
  output logic [1:0]             sc_data,
  output logic                   sc_en0,
  output logic                   sc_en1,
  input  logic                   sc_toggle,
  input  logic                   sc_vld0,
  input  logic                   sc_vld1,
  input  logic [SCORE_WIDTH-1:0] sc_result0,
  input  logic [SCORE_WIDTH-1:0] sc_result1,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   res_chan,
  output logic [SCORE_WIDTH-1:0] res_score,
  output logic [CNT_WIDTH-1:0]   res_len,
  output logic                   res_err,
  output logic                   busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RUN    = 2'd3;

  localparam logic [1:0] CIDLE  = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

`ifdef SW_FEEDER_TIMEOUT_EN
  localparam int TMO_LIMIT = 2 * LENGTH + 8;
  localparam int TMO_W     = $clog2(TMO_LIMIT + 1);
  logic [TMO_W-1:0] tmo_cnt [2];
`endif

  logic [1:0]             top_state;
  logic [ADDR_WIDTH-1:0]  qsel;
  logic                   run;
  logic                   srv;

  logic [1:0]             valid_v, last_v, vld_v, vld_prev, vld_rise;
  logic [1:0]             served_v, ready_v, hs_v, en_r, err_r;
  logic [1:0]             base_v   [2];
  logic [SCORE_WIDTH-1:0] result_v [2];
  logic [SCORE_WIDTH-1:0] cap_r    [2];
  logic [CNT_WIDTH-1:0]   len_r    [2];
  logic [1:0]             cst      [2];
  logic [1:0]             data_r;

  logic                   hold0, hold1, any_hold;
  logic                   sel, rr, pres_lock, pres_chan, pop;

  function automatic logic [SCORE_WIDTH-1:0] unbias(input logic [SCORE_WIDTH-1:0] r);
    return (r >= ZERO) ? (r - ZERO) : '0;
  endfunction

  assign run         = (top_state == RUN);
  assign srv         = ~sc_toggle;
  assign valid_v     = {tgt1_valid, tgt0_valid};
  assign last_v      = {tgt1_last, tgt0_last};
  assign vld_v       = {sc_vld1, sc_vld0};
  assign vld_rise    = vld_v & ~vld_prev;
  assign base_v[0]   = tgt0_base;
  assign base_v[1]   = tgt1_base;
  assign result_v[0] = sc_result0;
  assign result_v[1] = sc_result1;

  // Slot ownership and per-channel accept conditions
  always_comb begin
    served_v = '0;
    ready_v  = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      served_v[k] = run & (srv == 1'(k));
      ready_v[k]  = served_v[k] & ((cst[k] == CIDLE) | (cst[k] == STREAM));
    end
    hs_v = ready_v & valid_v;
  end

  // Top-level configuration sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      top_state <= IDLE;
      qsel      <= '0;
    end else begin
      case (top_state)
        IDLE: if (cfg_start) begin
          top_state <= LOAD;
          qsel      <= cfg_qlen;
        end
        LOAD:    top_state <= WAIT;
        WAIT:    if (sc_ready) top_state <= RUN;
        default: top_state <= RUN;
      endcase
    end
  end

  // Per-channel sequence FSMs: length count, underflow, result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_prev <= '0;
      err_r    <= '0;
      for (int unsigned k = 0; k < 2; k++) begin
        cst[k]   <= CIDLE;
        len_r[k] <= '0;
        cap_r[k] <= '0;
`ifdef SW_FEEDER_TIMEOUT_EN
        tmo_cnt[k] <= '0;
`endif
      end
    end else begin
      vld_prev <= vld_v;
      for (int unsigned k = 0; k < 2; k++) begin
`ifdef SW_FEEDER_TIMEOUT_EN
        tmo_cnt[k] <= (cst[k] == DRAIN) ? tmo_cnt[k] + TMO_W'(1) : '0;
`endif
        case (cst[k])
          CIDLE, STREAM: begin
            if (hs_v[k]) begin
              if (len_r[k] != '1) len_r[k] <= len_r[k] + CNT_WIDTH'(1);
              cst[k] <= last_v[k] ? DRAIN : STREAM;
            end else if (served_v[k] && cst[k] == STREAM) begin
              err_r[k] <= 1'b1;
              cst[k]   <= DRAIN;
            end
          end
          DRAIN: begin
            if (vld_rise[k]) begin
              cap_r[k] <= unbias(result_v[k]);
              cst[k]   <= HOLD;
            end
`ifdef SW_FEEDER_TIMEOUT_EN
            else if (tmo_cnt[k] == TMO_W'(TMO_LIMIT - 1)) begin
              cap_r[k] <= '0;
              err_r[k] <= 1'b1;
              cst[k]   <= HOLD;
            end
`endif
          end
          default: begin
            if (pop && sel == 1'(k)) begin
              len_r[k] <= '0;
              err_r[k] <= 1'b0;
              cst[k]   <= CIDLE;
            end
          end
        endcase
      end
    end
  end

  // Scorer data/enable for the slot being served; the other enable holds
  always_ff @(posedge clk) begin
    if (rst) begin
      en_r   <= '0;
      data_r <= '0;
    end else if (run) begin
      en_r[srv] <= hs_v[srv];
      if (hs_v[srv]) data_r <= base_v[srv];
    end
  end

  // Result selection: a presented result stays locked until it is taken
  always_comb begin
    hold0    = (cst[0] == HOLD);
    hold1    = (cst[1] == HOLD);
    any_hold = hold0 | hold1;
    if (pres_lock)           sel = pres_chan;
    else if (hold0 && hold1) sel = rr;
    else                     sel = ~hold0;
  end

  assign pop = any_hold & res_ready;

  // Round-robin pointer and presentation lock
  always_ff @(posedge clk) begin
    if (rst) begin
      rr        <= 1'b0;
      pres_lock <= 1'b0;
      pres_chan <= 1'b0;
    end else begin
      pres_lock <= any_hold & ~res_ready;
      pres_chan <= sel;
      if (pop) rr <= ~sel;
    end
  end

  assign sc_ld_p          = (top_state == LOAD);
  assign sc_ld_q          = (top_state == LOAD);
  assign sc_output_select = qsel;
  assign busy             = (top_state != IDLE);
  assign tgt0_ready       = ready_v[0];
  assign tgt1_ready       = ready_v[1];
  assign sc_data          = data_r;
  assign sc_en0           = en_r[0];
  assign sc_en1           = en_r[1];
  assign res_valid        = any_hold;
  assign res_chan         = any_hold & sel;
  assign res_score        = any_hold ? cap_r[sel] : '0;
  assign res_len          = any_hold ? len_r[sel] : '0;
  assign res_err          = any_hold & err_r[sel];

endmodule

// File: tb/tb_sw_target_feeder.sv
// Directed self-checking bench for sw_target_feeder with a toggling scorer model.
module tb_sw_target_feeder;
  localparam int SW = 12;
  localparam int AW = 9;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, cfg_start, sc_ready, sc_toggle;
  logic [AW-1:0] cfg_qlen;
  logic          sc_ld_p, sc_ld_q;
  logic [AW-1:0] sc_output_select;
  logic          tgt0_valid, tgt1_valid, tgt0_last, tgt1_last;
  logic [1:0]    tgt0_base, tgt1_base;
  logic          tgt0_ready, tgt1_ready;
  logic [1:0]    sc_data;
  logic          sc_en0, sc_en1, sc_vld0, sc_vld1;
  logic [SW-1:0] sc_result0, sc_result1;
  logic          res_valid, res_ready, res_chan, res_err, busy;
  logic [SW-1:0] res_score;
  logic [CW-1:0] res_len;

  int checks = 0;
  int failures = 0;
  int en0_cyc = 0;
  int en1_cyc = 0;

  sw_target_feeder #(.SCORE_WIDTH(SW), .LENGTH(128), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_qlen(cfg_qlen),
    .sc_ld_p(sc_ld_p), .sc_ld_q(sc_ld_q), .sc_output_select(sc_output_select),
    .sc_ready(sc_ready),
    .tgt0_valid(tgt0_valid), .tgt1_valid(tgt1_valid),
    .tgt0_base(tgt0_base), .tgt1_base(tgt1_base),
    .tgt0_last(tgt0_last), .tgt1_last(tgt1_last),
    .tgt0_ready(tgt0_ready), .tgt1_ready(tgt1_ready),
    .sc_data(sc_data), .sc_en0(sc_en0), .sc_en1(sc_en1),
    .sc_toggle(sc_toggle), .sc_vld0(sc_vld0), .sc_vld1(sc_vld1),
    .sc_result0(sc_result0), .sc_result1(sc_result1),
    .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan),
    .res_score(res_score), .res_len(res_len), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scorer model: toggle flips every cycle
  initial begin
    sc_toggle = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sc_toggle = ~sc_toggle;
    end
  end

  // Enable-occupancy counters
  always @(negedge clk) begin
    if (sc_en0) en0_cyc++;
    if (sc_en1) en1_cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [1:0] b, input logic l);
    int n;
    logic ok;
    n = 0; ok = 1'b0;
    tgt0_valid = 1'b1; tgt0_base = b; tgt0_last = l;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = tgt0_ready;
      @(posedge clk);
      #1;
      n++;
    end
    tgt0_valid = 1'b0; tgt0_last = 1'b0;
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL send0_accept got=%0d exp=1", ok); end
    else begin
      checks++;
      if (sc_en0 !== 1'b1) begin failures++; $display("FAIL send0_en got=%0d exp=1", sc_en0); end
      checks++;
      if (sc_data !== b) begin failures++; $display("FAIL send0_data got=%0d exp=%0d", sc_data, b); end
    end
  endtask

  task automatic send1(input logic [1:0] b, input logic l);
    int n;
    logic ok;
    n = 0; ok = 1'b0;
    tgt1_valid = 1'b1; tgt1_base = b; tgt1_last = l;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = tgt1_ready;
      @(posedge clk);
      #1;
      n++;
    end
    tgt1_valid = 1'b0; tgt1_last = 1'b0;
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL send1_accept got=%0d exp=1", ok); end
    else begin
      checks++;
      if (sc_en1 !== 1'b1) begin failures++; $display("FAIL send1_en got=%0d exp=1", sc_en1); end
      checks++;
      if (sc_data !== b) begin failures++; $display("FAIL send1_data got=%0d exp=%0d", sc_data, b); end
    end
  endtask

  task automatic setup();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    sc_ready = 1'b1; cfg_qlen = 9'd4; cfg_start = 1'b1;
    tick(); cfg_start = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_start = 1'b0; cfg_qlen = '0; sc_ready = 1'b0;
    tgt0_valid = 1'b0; tgt1_valid = 1'b0; tgt0_base = '0; tgt1_base = '0;
    tgt0_last = 1'b0; tgt1_last = 1'b0; sc_vld0 = 1'b0; sc_vld1 = 1'b0;
    sc_result0 = '0; sc_result1 = '0; res_ready = 1'b0;
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0d exp=0", busy); end
    checks++; if ({sc_ld_p, sc_ld_q} !== 2'b00) begin failures++; $display("FAIL rst_ld got=%0b exp=00", {sc_ld_p, sc_ld_q}); end
    checks++; if ({sc_en1, sc_en0} !== 2'b00) begin failures++; $display("FAIL rst_en got=%0b exp=00", {sc_en1, sc_en0}); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%0d exp=0", res_valid); end
    checks++; if (sc_output_select !== '0) begin failures++; $display("FAIL rst_osel got=%0d exp=0", sc_output_select); end
    checks++; if ({tgt1_ready, tgt0_ready} !== 2'b00) begin failures++; $display("FAIL rst_tready got=%0b exp=00", {tgt1_ready, tgt0_ready}); end
    rst = 1'b0;
  endtask

  task automatic test_config();
    cfg_qlen = 9'd4; cfg_start = 1'b1;
    tick(); cfg_start = 1'b0;
    checks++; if ({sc_ld_p, sc_ld_q} !== 2'b11) begin failures++; $display("FAIL cfg_load got=%0b exp=11", {sc_ld_p, sc_ld_q}); end
    checks++; if (sc_output_select !== 9'd4) begin failures++; $display("FAIL cfg_osel got=%0d exp=4", sc_output_select); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL cfg_busy got=%0d exp=1", busy); end
    tick();
    checks++; if ({sc_ld_p, sc_ld_q} !== 2'b00) begin failures++; $display("FAIL cfg_load_once got=%0b exp=00", {sc_ld_p, sc_ld_q}); end
    cfg_qlen = 9'd9; cfg_start = 1'b1;
    tick(); cfg_start = 1'b0;
    checks++; if (sc_output_select !== 9'd4) begin failures++; $display("FAIL cfg_start_ignored got=%0d exp=4", sc_output_select); end
    checks++; if ({tgt1_ready, tgt0_ready} !== 2'b00) begin failures++; $display("FAIL cfg_wait_noready got=%0b exp=00", {tgt1_ready, tgt0_ready}); end
    tick();
    checks++; if ({sc_ld_p, busy} !== 2'b01) begin failures++; $display("FAIL cfg_wait_busy got=%0b exp=01", {sc_ld_p, busy}); end
    sc_ready = 1'b1;
    tick();
    checks++; if ((tgt0_ready ^ tgt1_ready) !== 1'b1) begin failures++; $display("FAIL cfg_run_slot got=%0b exp=one-hot", {tgt1_ready, tgt0_ready}); end
  endtask

  task automatic test_stream_ch0();
    en0_cyc = 0; en1_cyc = 0; res_ready = 1'b0;
    send0(2'd0, 1'b0); send0(2'd1, 1'b0); send0(2'd2, 1'b0); send0(2'd3, 1'b1);
    tick(); tick(); tick();
    checks++; if (sc_en0 !== 1'b0) begin failures++; $display("FAIL ch0_en_drop got=%0d exp=0", sc_en0); end
    checks++; if (en0_cyc !== 8) begin failures++; $display("FAIL ch0_en_cycles got=%0d exp=8", en0_cyc); end
    checks++; if (en1_cyc !== 0) begin failures++; $display("FAIL ch0_en1_quiet got=%0d exp=0", en1_cyc); end
    sc_result0 = 12'd2055; sc_vld0 = 1'b1;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL ch0_latency got=%0d exp=0", res_valid); end
    tick();
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL ch0_res_valid got=%0d exp=1", res_valid); end
    checks++; if (res_chan !== 1'b0) begin failures++; $display("FAIL ch0_res_chan got=%0d exp=0", res_chan); end
    checks++; if (res_score !== 12'd7) begin failures++; $display("FAIL ch0_res_score got=%0d exp=7", res_score); end
    checks++; if (res_len !== 16'd4) begin failures++; $display("FAIL ch0_res_len got=%0d exp=4", res_len); end
    checks++; if (res_err !== 1'b0) begin failures++; $display("FAIL ch0_res_err got=%0d exp=0", res_err); end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL ch0_pop got=%0d exp=0", res_valid); end
    sc_vld0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    setup();
    en0_cyc = 0; en1_cyc = 0; res_ready = 1'b0;
    fork
      begin send0(2'd0, 1'b0); send0(2'd3, 1'b0); send0(2'd1, 1'b1); end
      begin send1(2'd2, 1'b0); send1(2'd2, 1'b0); send1(2'd0, 1'b1); end
    join
    tick(); tick(); tick();
    checks++; if (en0_cyc !== 6) begin failures++; $display("FAIL b2b_en0_cycles got=%0d exp=6", en0_cyc); end
    checks++; if (en1_cyc !== 6) begin failures++; $display("FAIL b2b_en1_cycles got=%0d exp=6", en1_cyc); end
    sc_result0 = 12'd2053; sc_result1 = 12'd2057; sc_vld0 = 1'b1; sc_vld1 = 1'b1; res_ready = 1'b1;
    tick();
    checks++; if ({res_valid, res_chan} !== 2'b10) begin failures++; $display("FAIL b2b_first_chan got=%0b exp=10", {res_valid, res_chan}); end
    checks++; if (res_score !== 12'd5) begin failures++; $display("FAIL b2b_first_score got=%0d exp=5", res_score); end
    checks++; if (res_len !== 16'd3) begin failures++; $display("FAIL b2b_first_len got=%0d exp=3", res_len); end
    tick();
    checks++; if ({res_valid, res_chan} !== 2'b11) begin failures++; $display("FAIL b2b_second_chan got=%0b exp=11", {res_valid, res_chan}); end
    checks++; if (res_score !== 12'd9) begin failures++; $display("FAIL b2b_second_score got=%0d exp=9", res_score); end
    checks++; if (res_len !== 16'd3) begin failures++; $display("FAIL b2b_second_len got=%0d exp=3", res_len); end
    tick();
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%0d exp=0", res_valid); end
    res_ready = 1'b0; sc_vld0 = 1'b0; sc_vld1 = 1'b0;
  endtask

  task automatic test_underflow();
    send1(2'd1, 1'b0); send1(2'd2, 1'b0);
    tick(); tick();
    checks++; if (sc_en1 !== 1'b0) begin failures++; $display("FAIL uf_en1_drop got=%0d exp=0", sc_en1); end
    sc_result1 = 12'd2051; sc_vld1 = 1'b1;
    tick();
    checks++; if ({res_valid, res_chan} !== 2'b11) begin failures++; $display("FAIL uf_chan got=%0b exp=11", {res_valid, res_chan}); end
    checks++; if (res_len !== 16'd2) begin failures++; $display("FAIL uf_len got=%0d exp=2", res_len); end
    checks++; if (res_err !== 1'b1) begin failures++; $display("FAIL uf_err got=%0d exp=1", res_err); end
    checks++; if (res_score !== 12'd3) begin failures++; $display("FAIL uf_score got=%0d exp=3", res_score); end
    res_ready = 1'b1; tick(); res_ready = 1'b0; sc_vld1 = 1'b0;
  endtask

  task automatic test_clamp_hold();
    send0(2'd1, 1'b0); send0(2'd3, 1'b1);
    tick(); tick();
    sc_result0 = 12'd2040; sc_vld0 = 1'b1; res_ready = 1'b0;
    tick();
    tgt0_valid = 1'b1; tgt0_base = 2'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({res_valid, res_chan} !== 2'b10) begin failures++; $display("FAIL hold_valid[%0d] got=%0b exp=10", i, {res_valid, res_chan}); end
      checks++; if (res_score !== 12'd0) begin failures++; $display("FAIL hold_clamp[%0d] got=%0d exp=0", i, res_score); end
      checks++; if (res_len !== 16'd2) begin failures++; $display("FAIL hold_len[%0d] got=%0d exp=2", i, res_len); end
      checks++; if (tgt0_ready !== 1'b0) begin failures++; $display("FAIL hold_tready[%0d] got=%0d exp=0", i, tgt0_ready); end
    end
    tgt0_valid = 1'b0;
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL hold_pop got=%0d exp=0", res_valid); end
    sc_vld0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    send0(2'd2, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if ({sc_en1, sc_en0} !== 2'b00) begin failures++; $display("FAIL rmid_en got=%0b exp=00", {sc_en1, sc_en0}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%0d exp=0", busy); end
    checks++; if (sc_output_select !== '0) begin failures++; $display("FAIL rmid_osel got=%0d exp=0", sc_output_select); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rmid_res_valid got=%0d exp=0", res_valid); end
    tgt0_valid = 1'b1; tgt0_base = 2'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({tgt0_ready, sc_en0} !== 2'b00) begin failures++; $display("FAIL rmid_ignored[%0d] got=%0b exp=00", i, {tgt0_ready, sc_en0}); end
    end
    tgt0_valid = 1'b0;
    setup();
    send0(2'd1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_config();
    test_stream_ch0();
    test_back_to_back();
    test_underflow();
    test_clamp_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
